// File: rtl/conv_stream_controller.sv
// conv_stream_controller
//
// Sequencing controller for a KxK convolver datapath. It pulses the weight
// write, meters a raster-order pixel stream into the datapath window, and
// tracks the row and column of each accepted pixel. A result is captured only
// when the window lies fully inside the current image. Captured results are
// offered on a valid/ready port. Output backpressure stalls the pixel stream,
// so no result is dropped.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-low
//   start        one-cycle pulse that begins a frame (honoured in IDLE only)
//   pixel_in     upstream pixel
//   pixel_valid  upstream pixel valid
//   pixel_ready  pixel accepted this cycle when pixel_valid is also high
//   dp_write     weight-register write strobe (one cycle per frame)
//   dp_pixel     pixel forwarded to the datapath (= pixel_in)
//   dp_shift_en  datapath window shift enable (= pixel_valid & pixel_ready)
//   dp_result    datapath add result, combinational from its window
//   out_data     captured result
//   out_valid    out_data valid
//   out_ready    downstream accepts out_data
//   out_last     qualifies out_valid: last result of the frame
//   busy         controller is in any state other than IDLE
//   done         one-cycle pulse at the end of a frame
module conv_stream_controller #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned KERNEL_SIZE = 5,
  parameter int unsigned IMAGE_SIZE  = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_valid,
  output logic                  pixel_ready,
  output logic                  dp_write,
  output logic [DATA_WIDTH-1:0] dp_pixel,
  output logic                  dp_shift_en,
  input  logic [DATA_WIDTH-1:0] dp_result,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam logic [CW-1:0] WinMin  = CW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] EdgeMax = CW'(IMAGE_SIZE - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StDrain} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic                  cap_pend_q, cap_pend_d;
  logic                  cap_last_q, cap_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  done_q, done_d;

  logic slot_free;
  logic capture;
  logic accept;
  logic in_window;
  logic at_last;

  // The output register can take a new result this cycle.
  assign slot_free = !out_valid_q || out_ready;
  assign capture   = cap_pend_q && slot_free;

  // A pending capture holds the stream until it can move into the output
  // register; otherwise its window would be shifted away.
  assign pixel_ready = (state_q == StStream) && (!cap_pend_q || slot_free);
  assign dp_shift_en = pixel_valid && pixel_ready;
  assign accept      = dp_shift_en;
  assign dp_pixel    = pixel_in;
  assign dp_write    = (state_q == StLoad);
  assign busy        = (state_q != StIdle);

  // Position refers to the pixel being accepted now; the window ending there
  // is complete only once KERNEL_SIZE-1 rows and columns precede it.
  assign in_window = (row_q >= WinMin) && (col_q >= WinMin);
  assign at_last   = (row_q == EdgeMax) && (col_q == EdgeMax);

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    cap_pend_d  = cap_pend_q;
    cap_last_d  = cap_last_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    // Capture samples dp_result before this edge's shift takes effect.
    if (capture) begin
      out_data_d  = dp_result;
      out_valid_d = 1'b1;
      out_last_d  = cap_last_q;
      cap_pend_d  = 1'b0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    // A same-edge accept re-arms cap_pend after the capture above cleared it.
    if (accept) begin
      if (in_window) begin
        cap_pend_d = 1'b1;
        cap_last_d = at_last;
      end
      if (col_q == EdgeMax) begin
        col_d = '0;
        row_d = (row_q == EdgeMax) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        state_d = StStream;
        row_d   = '0;
        col_d   = '0;
      end
      StStream: begin
        if (accept && at_last) state_d = StDrain;
      end
      StDrain: begin
        if (!cap_pend_q && slot_free) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      cap_pend_q  <= 1'b0;
      cap_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cap_pend_q  <= cap_pend_d;
      cap_last_q  <= cap_last_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

endmodule
